// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration slave: frame header width
// and the frame FSM state encoding.
package spi_cfg_pkg;

  localparam int HDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for one asynchronous SPI pin. The reset value is
// chosen per pin so that the synchronised output starts in a safe level.
module spi_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the pin twice on clk to settle metastability
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI slave register bridge. A frame is an 8-bit header (bit 7 = write
// flag, low ADDR_W bits = word address) followed by DATA_W data bits,
// MSB first. Written frames land in the MOSI bank (read by the CPU on
// Data_Read); the MISO bank (written by the CPU) is shifted back to the
// master during the data phase. All SPI pins are oversampled on Clk.
// Optional feature macro: SPI_SLAVE_CFG_IRQ_EN enables the receive
// interrupt SPI_IRQ (set on each committed write frame, cleared by IRQ_Clr).
// Handshake: there is no valid/ready pair; a SPI write is committed in the
// single Clk cycle that the last data bit is sampled, and the CPU write
// port accepts Data_Write on every Clk edge where Data_WE is high.
module spi_slave_cfg
  import spi_cfg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              SPI_CLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  input  logic              Data_WE,
  input  logic [31:0]       Data_Addr,
  input  logic [DATA_W-1:0] Data_Write,
  output logic [DATA_W-1:0] Data_Read,
  input  logic              IRQ_Clr,
  output logic              SPI_IRQ,
  output spi_state_e        dbg_state
);

  localparam int FRAME_W = HDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int DEPTH   = 1 << ADDR_W;

  logic sclk_s, cs_s, mosi_s, sclk_d;

  // SCLK starts at its idle level, CS starts "busy" so a CS held low
  // across reset release is never mistaken for a new frame.
  spi_sync2 #(.RST_VAL(CPOL)) u_sync_clk  (.clk(Clk), .reset_n(Reset_n), .d(SPI_CLK),  .q(sclk_s));
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_cs   (.clk(Clk), .reset_n(Reset_n), .d(SPI_CS),   .q(cs_s));
  spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(Clk), .reset_n(Reset_n), .d(SPI_MOSI), .q(mosi_s));

  logic rise, fall, lead, trail, sample_edge, shift_edge;

  // Delayed copy of synchronised SCLK for edge detection
  always_ff @(posedge Clk) begin
    if (!Reset_n) sclk_d <= CPOL;
    else          sclk_d <= sclk_s;
  end

  assign rise        = sclk_s & ~sclk_d;
  assign fall        = ~sclk_s & sclk_d;
  assign lead        = CPOL ? fall : rise;
  assign trail       = CPOL ? rise : fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  logic [DATA_W-1:0] mosi_bank [DEPTH];
  logic [DATA_W-1:0] miso_bank [DEPTH];

  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [ADDR_W-1:0] addr;
  logic              wr_flag;
  logic              armed;
  logic              miso_q;

  logic [HDR_W-1:0]  hdr_next;
  logic [DATA_W-1:0] data_next;
  logic [ADDR_W-1:0] cpu_addr;
  logic              last_hdr, last_data, commit;

  assign cpu_addr  = Data_Addr[ADDR_W+1:2];
  assign hdr_next  = {rx_sh[HDR_W-2:0], mosi_s};
  assign data_next = {rx_sh[DATA_W-2:0], mosi_s};
  assign last_hdr  = (bit_cnt == CNT_W'(HDR_W - 1));
  assign last_data = (bit_cnt == CNT_W'(FRAME_W - 1));
  assign commit    = Reset_n && (state == DATA) && !cs_s && sample_edge
                     && last_data && wr_flag;

  // Frame FSM: header/data shifting, MISO load and serial output
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      addr    <= '0;
      wr_flag <= 1'b0;
      armed   <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      armed <= armed | cs_s;
      if (cs_s) begin
        state   <= IDLE;
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              state   <= HDR;
              bit_cnt <= '0;
              miso_q  <= 1'b0;
            end
          end
          HDR: begin
            if (shift_edge) miso_q <= 1'b0;
            if (sample_edge) begin
              rx_sh   <= data_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_hdr) begin
                state   <= DATA;
                wr_flag <= hdr_next[HDR_W-1];
                addr    <= hdr_next[ADDR_W-1:0];
                tx_sh   <= miso_bank[hdr_next[ADDR_W-1:0]];
              end
            end
          end
          DATA: begin
            if (shift_edge) begin
              miso_q <= tx_sh[DATA_W-1];
              tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
            end
            if (sample_edge) begin
              rx_sh   <= data_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_data) state <= DONE;
            end
          end
          DONE: begin
            // SCLK edges are ignored until CS rises
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // CPU writes into the MISO bank; a same-cycle header load reads the old word
  always_ff @(posedge Clk) begin
    if (Data_WE) miso_bank[cpu_addr] <= Data_Write;
  end

  // Completed write frames land in the MOSI bank
  always_ff @(posedge Clk) begin
    if (commit) mosi_bank[addr] <= data_next;
  end

  assign Data_Read = mosi_bank[cpu_addr];
  assign SPI_MISO  = miso_q;
  assign dbg_state = state;

  logic unused_bits;
  assign unused_bits = &{1'b0, Data_Addr[31:ADDR_W+2], Data_Addr[1:0],
                         hdr_next, rx_sh[DATA_W-1]};

`ifdef SPI_SLAVE_CFG_IRQ_EN
  logic irq_q;

  // Receive interrupt: a commit wins over a simultaneous clear
  always_ff @(posedge Clk) begin
    if (!Reset_n)     irq_q <= 1'b0;
    else if (commit)  irq_q <= 1'b1;
    else if (IRQ_Clr) irq_q <= 1'b0;
  end

  assign SPI_IRQ = irq_q;
`else
  logic unused_irq;
  assign unused_irq = IRQ_Clr;
  assign SPI_IRQ    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench for spi_slave_cfg: three instances (mode 0 default size,
// mode 3 default size, 16-bit/2-bit-address CPHA=1) driven by a bit-banged
// SPI master task with hand-computed expected values.
module tb_spi_slave_cfg;
  import spi_cfg_pkg::*;

  localparam int H = 8;  // Clk cycles per SCLK half period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [2:0]  sclk, cs, mosi, we, irq_clr;
  logic [31:0] addr0, addr1, addr2;
  logic [31:0] wd0, wd1;
  logic [15:0] wd2;
  logic        miso0, miso1, miso2, irq0, irq1, irq2;
  logic [31:0] rd0, rd1;
  logic [15:0] rd2;
  spi_state_e  st0, st1, st2;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_irq;

  spi_slave_cfg #(.DATA_W(32), .ADDR_W(4), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .Clk(clk), .Reset_n(rst_n), .SPI_CLK(sclk[0]), .SPI_CS(cs[0]), .SPI_MOSI(mosi[0]),
    .SPI_MISO(miso0), .Data_WE(we[0]), .Data_Addr(addr0), .Data_Write(wd0),
    .Data_Read(rd0), .IRQ_Clr(irq_clr[0]), .SPI_IRQ(irq0), .dbg_state(st0));

  spi_slave_cfg #(.DATA_W(32), .ADDR_W(4), .CPOL(1'b1), .CPHA(1'b1)) u1 (
    .Clk(clk), .Reset_n(rst_n), .SPI_CLK(sclk[1]), .SPI_CS(cs[1]), .SPI_MOSI(mosi[1]),
    .SPI_MISO(miso1), .Data_WE(we[1]), .Data_Addr(addr1), .Data_Write(wd1),
    .Data_Read(rd1), .IRQ_Clr(irq_clr[1]), .SPI_IRQ(irq1), .dbg_state(st1));

  spi_slave_cfg #(.DATA_W(16), .ADDR_W(2), .CPOL(1'b0), .CPHA(1'b1)) u2 (
    .Clk(clk), .Reset_n(rst_n), .SPI_CLK(sclk[2]), .SPI_CS(cs[2]), .SPI_MOSI(mosi[2]),
    .SPI_MISO(miso2), .Data_WE(we[2]), .Data_Addr(addr2), .Data_Write(wd2),
    .Data_Read(rd2), .IRQ_Clr(irq_clr[2]), .SPI_IRQ(irq2), .dbg_state(st2));

  // ---------------- driver tasks ----------------
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic get_miso(input int d);
    case (d)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction

  function automatic spi_state_e get_state(input int d);
    case (d)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  task automatic set_addr(input int d, input logic [31:0] a);
    case (d)
      0:       addr0 = a;
      1:       addr1 = a;
      default: addr2 = a;
    endcase
  endtask

  task automatic cpu_write(input int d, input logic [31:0] a, input logic [31:0] v);
    set_addr(d, a);
    case (d)
      0:       wd0 = v;
      1:       wd1 = v;
      default: wd2 = v[15:0];
    endcase
    we[d] = 1'b1;
    clks(1);
    we[d] = 1'b0;
  endtask

  task automatic pulse_clr(input int d);
    irq_clr[d] = 1'b1;
    clks(1);
    irq_clr[d] = 1'b0;
  endtask

  // Wait after a sample edge; drop a held IRQ_Clr as soon as DONE shows up
  task automatic wait_after_sample(input int d, inout bit hit);
    for (int k = 0; k < H; k++) begin
      clks(1);
      if (irq_clr[d] && get_state(d) == DONE) begin
        irq_clr[d] = 1'b0;
        hit = 1'b1;
      end
    end
  endtask

  // Bit-banged SPI master. txb is low-aligned (bit nbits-1 goes first).
  task automatic spi_frame(input int d, input int nbits, input logic [39:0] txb,
                           input int stop_at, input int rst_at, input int extra,
                           input bit clr_last, output logic [39:0] rxb,
                           output spi_state_e end_st, output bit hit);
    bit cpol, cpha;
    cpol = (d == 1);
    cpha = (d != 0);
    rxb  = '0;
    hit  = 1'b0;
    cs[d] = 1'b0;
    clks(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == stop_at) break;
      if (i == rst_at) begin
        rst_n = 1'b0;
        clks(2);
        rst_n = 1'b1;
      end
      if (clr_last && i == nbits - 1) irq_clr[d] = 1'b1;
      if (!cpha) begin
        mosi[d] = txb[nbits-1-i];
        clks(H);
        rxb = {rxb[38:0], get_miso(d)};
        sclk[d] = ~cpol;
        wait_after_sample(d, hit);
        sclk[d] = cpol;
      end else begin
        sclk[d] = ~cpol;
        mosi[d] = txb[nbits-1-i];
        clks(H);
        rxb = {rxb[38:0], get_miso(d)};
        sclk[d] = cpol;
        wait_after_sample(d, hit);
      end
    end
    for (int e = 0; e < extra; e++) begin
      mosi[d] = 1'($urandom_range(0, 1));
      sclk[d] = ~cpol;
      clks(H);
      sclk[d] = cpol;
      clks(H);
    end
    clks(H);
    end_st = get_state(d);
    cs[d] = 1'b1;
    clks(8);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    clks(4);
    n_checks++; if (miso0 !== 1'b0) begin n_fail++; $display("FAIL reset_miso0: got %b expected 0", miso0); end
    n_checks++; if (miso1 !== 1'b0) begin n_fail++; $display("FAIL reset_miso1: got %b expected 0", miso1); end
    n_checks++; if (miso2 !== 1'b0) begin n_fail++; $display("FAIL reset_miso2: got %b expected 0", miso2); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq0: got %b expected 0", irq0); end
    n_checks++; if (st0 !== IDLE) begin n_fail++; $display("FAIL reset_state0: got %0d expected %0d", st0, IDLE); end
    rst_n = 1'b1;
    clks(4);
    n_checks++; if (st1 !== IDLE) begin n_fail++; $display("FAIL post_reset_state1: got %0d expected %0d", st1, IDLE); end
  endtask

  task automatic test_write_mode0();
    logic [39:0] rxb; spi_state_e es; bit hit;
    cpu_write(0, 32'h0C, 32'hCAFEF00D);
    spi_frame(0, 40, {8'h83, 32'hDEADBEEF}, 99, 99, 2, 1'b0, rxb, es, hit);
    n_checks++; if (rxb[39:32] !== 8'h00) begin n_fail++; $display("FAIL m0_hdr_miso: got %h expected 00", rxb[39:32]); end
    n_checks++; if (rxb[31:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL m0_data_miso: got %h expected cafef00d", rxb[31:0]); end
    n_checks++; if (es !== DONE) begin n_fail++; $display("FAIL m0_end_state: got %0d expected %0d", es, DONE); end
    set_addr(0, 32'h0C);
    clks(1);
    n_checks++; if (rd0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL m0_read: got %h expected deadbeef", rd0); end
    n_checks++; if (st0 !== IDLE) begin n_fail++; $display("FAIL m0_idle: got %0d expected %0d", st0, IDLE); end
    n_checks++; if (irq0 !== exp_irq) begin n_fail++; $display("FAIL m0_irq: got %b expected %b", irq0, exp_irq); end
  endtask

  task automatic test_read_mode3();
    logic [39:0] rxb; spi_state_e es; bit hit;
    cpu_write(1, 32'h14, 32'h12345678);
    spi_frame(1, 40, {8'h85, 32'h0BADF00D}, 99, 99, 0, 1'b0, rxb, es, hit);
    n_checks++; if (rxb[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL m3_wr_miso: got %h expected 12345678", rxb[31:0]); end
    set_addr(1, 32'h14);
    clks(1);
    n_checks++; if (rd1 !== 32'h0BADF00D) begin n_fail++; $display("FAIL m3_wr_read: got %h expected 0badf00d", rd1); end
    n_checks++; if (irq1 !== exp_irq) begin n_fail++; $display("FAIL m3_irq: got %b expected %b", irq1, exp_irq); end
    pulse_clr(1);
    spi_frame(1, 40, {8'h05, 32'hFFFFFFFF}, 99, 99, 0, 1'b0, rxb, es, hit);
    n_checks++; if (rxb[39:32] !== 8'h00) begin n_fail++; $display("FAIL m3_hdr_miso: got %h expected 00", rxb[39:32]); end
    n_checks++; if (rxb[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL m3_rd_miso: got %h expected 12345678", rxb[31:0]); end
    clks(1);
    n_checks++; if (rd1 !== 32'h0BADF00D) begin n_fail++; $display("FAIL m3_bank_kept: got %h expected 0badf00d", rd1); end
    n_checks++; if (irq1 !== 1'b0) begin n_fail++; $display("FAIL m3_rd_no_irq: got %b expected 0", irq1); end
  endtask

  task automatic test_abort();
    logic [39:0] rxb; spi_state_e es; bit hit;
    spi_frame(0, 40, {8'h81, 32'h11112222}, 99, 99, 0, 1'b0, rxb, es, hit);
    set_addr(0, 32'h04);
    clks(1);
    n_checks++; if (rd0 !== 32'h11112222) begin n_fail++; $display("FAIL abort_pre: got %h expected 11112222", rd0); end
    pulse_clr(0);
    spi_frame(0, 40, {8'h81, 32'h33334444}, 20, 99, 0, 1'b0, rxb, es, hit);
    n_checks++; if (rd0 !== 32'h11112222) begin n_fail++; $display("FAIL abort_kept: got %h expected 11112222", rd0); end
    n_checks++; if (st0 !== IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d expected %0d", st0, IDLE); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL abort_irq: got %b expected 0", irq0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] rxb; spi_state_e es; bit hit;
    cpu_write(0, 32'h08, 32'hFFFFFFFF);
    spi_frame(0, 40, {8'h82, 32'h55556666}, 99, 99, 0, 1'b0, rxb, es, hit);
    pulse_clr(0);
    spi_frame(0, 40, {8'h82, 32'h77778888}, 99, 16, 0, 1'b0, rxb, es, hit);
    n_checks++; if (rxb[31:24] !== 8'hFF) begin n_fail++; $display("FAIL rst_miso_before: got %h expected ff", rxb[31:24]); end
    n_checks++; if (rxb[23:0] !== 24'h000000) begin n_fail++; $display("FAIL rst_miso_after: got %h expected 000000", rxb[23:0]); end
    set_addr(0, 32'h08);
    clks(1);
    n_checks++; if (rd0 !== 32'h55556666) begin n_fail++; $display("FAIL rst_no_write: got %h expected 55556666", rd0); end
    n_checks++; if (miso0 !== 1'b0) begin n_fail++; $display("FAIL rst_miso_idle: got %b expected 0", miso0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b expected 0", irq0); end
    spi_frame(0, 40, {8'h82, 32'h9999AAAA}, 99, 99, 0, 1'b0, rxb, es, hit);
    n_checks++; if (rxb[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rst_next_miso: got %h expected ffffffff", rxb[31:0]); end
    clks(1);
    n_checks++; if (rd0 !== 32'h9999AAAA) begin n_fail++; $display("FAIL rst_next_write: got %h expected 9999aaaa", rd0); end
  endtask

  task automatic test_cfg16();
    logic [39:0] rxb; spi_state_e es; bit hit;
    cpu_write(2, 32'h08, 32'h00003C5A);
    spi_frame(2, 24, 40'h0000_82A5C3, 99, 99, 0, 1'b0, rxb, es, hit);
    n_checks++; if (rxb[23:16] !== 8'h00) begin n_fail++; $display("FAIL w16_hdr_miso: got %h expected 00", rxb[23:16]); end
    n_checks++; if (rxb[15:0] !== 16'h3C5A) begin n_fail++; $display("FAIL w16_data_miso: got %h expected 3c5a", rxb[15:0]); end
    set_addr(2, 32'h08);
    clks(1);
    n_checks++; if (rd2 !== 16'hA5C3) begin n_fail++; $display("FAIL w16_read: got %h expected a5c3", rd2); end
    n_checks++; if (irq2 !== exp_irq) begin n_fail++; $display("FAIL w16_irq: got %b expected %b", irq2, exp_irq); end
  endtask

  task automatic test_irq();
    logic [39:0] rxb; spi_state_e es; bit hit;
    pulse_clr(0);
    spi_frame(0, 40, {8'h84, 32'h0F0F0F0F}, 99, 99, 0, 1'b1, rxb, es, hit);
    irq_clr[0] = 1'b0;
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL irq_commit_seen: got %b expected 1", hit); end
    clks(2);
    n_checks++; if (irq0 !== exp_irq) begin n_fail++; $display("FAIL irq_commit_wins: got %b expected %b", irq0, exp_irq); end
    set_addr(0, 32'h10);
    clks(1);
    n_checks++; if (rd0 !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL irq_frame_write: got %h expected 0f0f0f0f", rd0); end
    pulse_clr(0);
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_cleared: got %b expected 0", irq0); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
`ifdef SPI_SLAVE_CFG_IRQ_EN
    exp_irq = 1'b1;
`else
    exp_irq = 1'b0;
`endif
    rst_n = 1'b0;
    sclk = 3'b010;
    cs = 3'b111;
    mosi = 3'b000;
    we = 3'b000;
    irq_clr = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wd0 = '0; wd1 = '0; wd2 = '0;
    test_reset();
    test_write_mode0();
    test_read_mode3();
    test_abort();
    test_reset_mid_frame();
    test_cfg16();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
